// File: rtl/imem_program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader_pkg
// Description : Shared definitions for the instruction-memory program loader.
//               Holds the instruction memory geometry (shared with the
//               instruction memory itself), the loader state encoding and the
//               length-field size of the load stream.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_program_loader_pkg;

    // Word-address bits of the instruction memory; must match its address width.
    localparam int SIZE_INST = 5;
    // Number of 32-bit rows in instruction memory.
    localparam int ROWS      = 1 << SIZE_INST;
    // Bytes in the little-endian word-count header (and in every data word).
    localparam int LEN_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage : imem_program_loader_pkg
`default_nettype wire

// File: rtl/imem_program_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Collects bytes into a little-endian 32-bit word. A 2-bit byte
//               counter wraps every four accepted bytes; word_complete_o
//               pulses combinationally on the fourth accepted byte, at which
//               point word_next_o carries the complete word (first byte in
//               bits [7:0]).
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clear_i         - drop any partial word, zero the counter
//               accept_i        - a byte transfer happens this cycle
//               byte_i          - the transferred byte
//               word_next_o     - word including the current byte
//               word_complete_o - current byte completes a word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_next_o,
    output logic        word_complete_o
);

    logic [1:0]  cnt_q;
    // Only the three most recent bytes need storing: the fourth byte is
    // consumed straight from byte_i when the word completes.
    logic [23:0] shift_q;

    // New bytes enter at the top and older bytes move down, so after four
    // bytes the first one sits in bits [7:0].
    assign word_next_o     = {byte_i, shift_q};
    assign word_complete_o = accept_i && (cnt_q == 2'(LEN_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (accept_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= word_next_o[31:8];
        end
    end

endmodule : byte_word_assembler
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Writer side of the instruction memory. Receives a byte stream
//               (4-byte little-endian word count N, then N little-endian
//               words), writes each word to consecutive word addresses
//               (wrapping modulo ROWS) and holds the CPU while loading.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start_i             - begin a load (honoured in IDLE/DONE)
//               byte_valid_i/data_i - byte source
//               byte_ready_o        - loader accepts a byte this cycle
//               imem_we_o/addr_o/wdata_o - instruction memory write port
//               cpu_hold_o          - CPU must not advance while high
//               load_done_o         - load finished
//               load_error_o        - sticky: word count exceeded ROWS
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import imem_program_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    output logic                 byte_ready_o,
    output logic                 imem_we_o,
    output logic [SIZE_INST-1:0] imem_addr_o,
    output logic [31:0]          imem_wdata_o,
    output logic                 cpu_hold_o,
    output logic                 load_done_o,
    output logic                 load_error_o
);

    state_e                 state_q;
    logic                   byte_ready_q;
    logic                   imem_we_q;
    logic [SIZE_INST-1:0]   imem_addr_q;
    logic [31:0]            imem_wdata_q;
    logic                   cpu_hold_q;
    logic                   load_done_q;
    logic                   load_error_q;
    logic [31:0]            len_q;
    logic [31:0]            word_cnt_q;
    logic [31:0]            word_cnt_d;

    logic                   w_accept;
    logic                   w_clear;
    logic [31:0]            w_word_next;
    logic                   w_word_complete;

    // byte_ready is only ever high in LEN/DATA, so this is the full
    // transfer condition.
    assign w_accept   = byte_valid_i && byte_ready_q;
    assign w_clear    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign word_cnt_d = word_cnt_q + 32'd1;

    byte_word_assembler u_assembler (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (w_clear),
        .accept_i        (w_accept),
        .byte_i          (byte_data_i),
        .word_next_o     (w_word_next),
        .word_complete_o (w_word_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            len_q        <= 32'd0;
            word_cnt_q   <= 32'd0;
        end else begin
            // The write strobe lives for exactly the single WRITE cycle.
            imem_we_q <= 1'b0;

            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q      <= ST_LEN;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_error_q <= 1'b0;
                        word_cnt_q   <= 32'd0;
                    end
                end

                ST_LEN: begin
                    if (w_word_complete) begin
                        len_q <= w_word_next;
                        if (w_word_next == 32'd0) begin
                            state_q      <= ST_DONE;
                            byte_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            load_done_q  <= 1'b1;
                        end else begin
                            // Oversized loads still run to completion; later
                            // words simply overwrite earlier rows.
                            if (w_word_next > 32'(ROWS)) begin
                                load_error_q <= 1'b1;
                            end
                            state_q <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_word_complete) begin
                        state_q      <= ST_WRITE;
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_cnt_q[SIZE_INST-1:0];
                        imem_wdata_q <= w_word_next;
                    end
                end

                ST_WRITE: begin
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == len_q) begin
                        state_q     <= ST_DONE;
                        cpu_hold_q  <= 1'b0;
                        load_done_q <= 1'b1;
                    end else begin
                        state_q      <= ST_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    cpu_hold_q   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign load_done_o  = load_done_q;
    assign load_error_o = load_error_q;

endmodule : imem_program_loader
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words and drives a word-aligned write port into instruction memory.
- Holds the CPU in hold while loading, so a program can be replaced at run time instead of only at elaboration from a file.
- Sits between the serial/byte source and the instruction memory write port; the CPU fetch path is untouched.

Parameters:
- SIZE_INST, 5, number of word-address bits; must equal the instruction memory address width.
- ROWS, 1 << SIZE_INST, number of 32-bit rows in instruction memory.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- byte_valid  in  1  byte source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle; a transfer occurs when byte_valid and byte_ready are both high.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  SIZE_INST  word address; equals byte address bits [SIZE_INST+1:2].
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  high while loading; CPU must not advance the PC.
- load_done  out  1  high in DONE; cleared by start or reset.
- load_error  out  1  sticky; word count exceeded ROWS; cleared by start or reset.

Behaviour:
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 0, load_done 0, load_error 0, byte counter 0, word counter 0.
- Stream format: 4 length bytes N (little-endian, 32-bit word count), then N words, each 4 bytes little-endian. The first data byte is imem_wdata[7:0].
- IDLE: byte_ready 0. On start, go to LEN, clear load_done and load_error, zero the counters, raise cpu_hold.
- LEN: byte_ready 1. Shift in 4 bytes. On the 4th accepted byte, latch N.
  - If N == 0, go to DONE.
  - Otherwise, if N > ROWS, set load_error. Then go to DATA.
- DATA: byte_ready 1 except in the write cycle. On the 4th accepted byte of a word, go to WRITE.
- WRITE: exactly one cycle.
  - imem_we = 1, imem_addr = word counter mod ROWS, imem_wdata = assembled word, byte_ready 0.
  - Increment the word counter.
  - If the counter reaches N, go to DONE; otherwise go to DATA.
- Latency: the write strobe is asserted the cycle after the 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- DONE: cpu_hold 0, load_done 1, byte_ready 0. A start pulse begins a new load (to LEN).
- Wrap-around: addresses wrap modulo ROWS, matching the instruction memory wrap. With N > ROWS, later words overwrite earlier rows. load_error flags this; the load still completes.
- Byte counter is 2 bits and wraps every 4 accepted bytes. The word counter is 32 bits and compared against N.
- Idle byte_valid (no transfer) leaves all state unchanged; partial words are held indefinitely.
- start while in LEN, DATA or WRITE: ignored.
- Bytes offered in IDLE or DONE: not accepted (byte_ready 0).
- Reset mid-load: immediate return to reset values; the partial word is discarded and cpu_hold drops.
- imem_we is never high outside WRITE; at most one write per 4 accepted data bytes.

Decomposition:
- Shared package: SIZE_INST/ROWS defines (shared with instruction memory), state encoding (IDLE, LEN, DATA, WRITE, DONE), and a LEN_BYTES=4 constant.
- One natural sub-module, byte_word_assembler: 2-bit byte counter plus 32-bit little-endian shift register with a word_complete pulse. It is reused in LEN and DATA.

Test Plan:
- Reset, then start, then stream 01 00 00 00 13 05 10 00 (N=1, word 0x00100513) -> one imem_we with addr 0, wdata 0x00100513; cpu_hold high from the cycle after start until DONE; load_done=1; load_error=0.
- N=3 streamed with byte_valid toggled every other cycle -> writes to addr 0,1,2 in order with the correct words; no write while a word is partial; byte_ready=0 in each WRITE cycle.
- N=0 (00 00 00 00) -> DONE with no imem_we; load_done=1.
- N=33 with ROWS=32, word k = k -> load_error=1 after the length is latched; the 33rd write goes to addr 0 with wdata 32; load_done=1.
- Reset asserted after 2 data bytes -> all outputs at reset values next cycle; a new start plus a full stream loads correctly from addr 0.
- start pulsed during DATA, and bytes offered in IDLE -> start ignored, load completes normally; no byte accepted in IDLE (byte_ready=0).
